map_set_counter: RTL and testbench

MAP_SET_COUNTER -- requirements
Module: map_set_counter

---
 rtl/map_set_counter_pkg.sv | 57 +++++
 rtl/map_set_counter_if.sv | 24 ++
 rtl/map_gen.sv | 66 ++++++
 rtl/map_popcount.sv | 69 ++++++
 rtl/map_set_counter.sv | 172 +++++++++++++++++
 tb/tb_map_set_counter.sv | 220 ++++++++++++++++++++++
 6 files changed

// File: rtl/map_set_counter_pkg.sv
// Shared types and helpers for the map set counter and its map generator.
// Build option: MAP_SET_SERIAL_COUNT_EN selects a bit-serial popcount.
package map_set_counter_pkg;

  localparam int MAP_W = 64;

  localparam logic [3:0] COORD_MIN = 4'd1;
  localparam logic [3:0] COORD_MAX = 4'd8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COMBINE = 3'd3;
  localparam logic [2:0] S_COUNT   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_AND    = 2'd1,
    MODE_XOR    = 2'd2,
    MODE_OR     = 2'd3
  } mode_e;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] r;
  } circ_t;

  function automatic circ_t circ_sel(
    input logic [23:0] c,
    input logic [11:0] rad,
    input logic [1:0]  i
  );
    circ_t o;
    case (i)
      2'd0:    o = {c[23:20], c[19:16], rad[11:8]};
      2'd1:    o = {c[15:12], c[11:8], rad[7:4]};
      default: o = {c[7:4], c[3:0], rad[3:0]};
    endcase
    return o;
  endfunction

  function automatic logic circ_ok(input circ_t c);
    return (c.x >= COORD_MIN) && (c.x <= COORD_MAX) &&
           (c.y >= COORD_MIN) && (c.y <= COORD_MAX);
  endfunction

  function automatic logic [1:0] last_idx(input mode_e m);
    case (m)
      MODE_SINGLE: return 2'd0;
      MODE_OR:     return 2'd2;
      default:     return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/map_set_counter_if.sv
// Link between the set counter and the circle map generator.
// master drives circle parameters, slave returns the map.
interface map_set_counter_if
  import map_set_counter_pkg::*;
#(
  parameter int MAP_BITS = MAP_W
);
  logic [3:0]          map_x;
  logic [3:0]          map_y;
  logic [3:0]          map_r;
  logic                map_reset;
  logic [MAP_BITS-1:0] map;
  logic                map_done;

  modport master (
    output map_x, map_y, map_r, map_reset,
    input  map, map_done
  );

  modport slave (
    input  map_x, map_y, map_r, map_reset,
    output map, map_done
  );
endinterface

// File: rtl/map_gen.sv
// Reference circle map generator: fills an 8x8 disc map a few
// cycles after map_reset drops, then holds map_done high.
module map_gen
  import map_set_counter_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  map_set_counter_if.slave g
);

  logic [1:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [MAP_W-1:0] map_q, map_d;

  // row 0 / column 0 is shifted in first and ends at the MSB
  function automatic logic [MAP_W-1:0] disc(
    input logic [3:0] cx,
    input logic [3:0] cy,
    input logic [3:0] r
  );
    logic [MAP_W-1:0] m;
    int dx, dy;
    m = '0;
    for (int row = 0; row < 8; row++) begin
      for (int col = 0; col < 8; col++) begin
        dx = col + 1 - int'(cx);
        dy = row + 1 - int'(cy);
        m  = {m[MAP_W-2:0], (dx*dx + dy*dy <= int'(r)*int'(r))};
      end
    end
    return m;
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    map_d  = map_q;
    if (g.map_reset) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (!done_q) begin
      if (cnt_q == 2'd2) begin
        done_d = 1'b1;
        map_d  = disc(g.map_x, g.map_y, g.map_r);
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  assign g.map      = map_q;
  assign g.map_done = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      map_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      map_q  <= map_d;
    end
  end

endmodule

// File: rtl/map_popcount.sv
// Population count of the combined map.
// MAP_SET_SERIAL_COUNT_EN: one bit per cycle; otherwise single-cycle.
module map_popcount
  import map_set_counter_pkg::*;
#(
  parameter int MAP_BITS = MAP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [MAP_BITS-1:0] data,
  output logic                done,
  output logic [6:0]          count
);

`ifdef MAP_SET_SERIAL_COUNT_EN
  localparam int CW = $clog2(MAP_BITS);
  localparam logic [CW-1:0] LAST = CW'(MAP_BITS - 1);

  logic [CW-1:0]       bit_q, bit_d;
  logic [6:0]          sum_q, sum_d;
  logic [MAP_BITS-1:0] sh_q, sh_d, cur;

  // bit 0 of a pass reloads the shifter and restarts the sum
  always_comb begin
    bit_d = bit_q;
    sum_d = sum_q;
    sh_d  = sh_q;
    cur   = (bit_q == '0) ? data : sh_q;
    if (en) begin
      sum_d = ((bit_q == '0) ? 7'd0 : sum_q)
            + {6'd0, cur[MAP_BITS-1]};
      sh_d  = cur << 1;
      bit_d = bit_q + CW'(1);
    end
  end

  assign done  = en && (bit_q == LAST);
  assign count = sum_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_q <= '0;
      sum_q <= '0;
      sh_q  <= '0;
    end else begin
      bit_q <= bit_d;
      sum_q <= sum_d;
      sh_q  <= sh_d;
    end
  end
`else
  logic [MAP_BITS-1:0] sh;
  logic                unused_clk_rst;

  assign unused_clk_rst = clk ^ reset;
  assign done = en;

  always_comb begin
    count = '0;
    sh    = data;
    for (int i = 0; i < MAP_BITS; i++) begin
      count = count + {6'd0, sh[0]};
      sh    = sh >> 1;
    end
  end
`endif

endmodule

// File: rtl/map_set_counter.sv
// Combines up to three circle maps (AND/XOR/OR) and counts set cells.
// Build option: MAP_SET_SERIAL_COUNT_EN (64-cycle serial popcount).
module map_set_counter
  import map_set_counter_pkg::*;
#(
  parameter int MAP_BITS = MAP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [23:0]         central,
  input  logic [11:0]         radius,
  output logic [3:0]          map_x,
  output logic [3:0]          map_y,
  output logic [3:0]          map_r,
  output logic                map_reset,
  input  logic [MAP_BITS-1:0] map,
  input  logic                map_done,
  output logic                busy,
  output logic                valid,
  output logic [6:0]          count
);

  logic [2:0]          state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [23:0]         central_q, central_d;
  logic [11:0]         radius_q, radius_d;
  logic [1:0]          idx_q, idx_d;
  logic [MAP_BITS-1:0] acc_q, acc_d;
  logic [MAP_BITS-1:0] cap_q, cap_d;
  logic [3:0]          mx_q, mx_d;
  logic [3:0]          my_q, my_d;
  logic [3:0]          mr_q, mr_d;
  logic [6:0]          count_q, count_d;
  logic                valid_q, valid_d;

  circ_t      first_c, next_c;
  logic       pc_en, pc_done;
  logic [6:0] pc_count;

  assign first_c = circ_sel(central, radius, 2'd0);
  assign next_c  = circ_sel(central_q, radius_q, idx_q + 2'd1);
  assign pc_en   = (state_q == S_COUNT);

  map_popcount #(
    .MAP_BITS (MAP_BITS)
  ) u_pop (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .data  (acc_q),
    .done  (pc_done),
    .count (pc_count)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    central_d = central_q;
    radius_d  = radius_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    cap_d     = cap_q;
    mx_d      = mx_q;
    my_d      = my_q;
    mr_d      = mr_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d    = mode_e'(mode);
          central_d = central;
          radius_d  = radius;
          idx_d     = 2'd0;
          acc_d     = '0;
          cap_d     = '0;
          // off-grid circles bypass the generator with an empty map
          if (circ_ok(first_c)) begin
            state_d = S_LOAD;
            mx_d    = first_c.x;
            my_d    = first_c.y;
            mr_d    = first_c.r;
          end else begin
            state_d = S_COMBINE;
          end
        end
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (map_done) begin
          cap_d   = map;
          state_d = S_COMBINE;
        end
      end
      S_COMBINE: begin
        if (idx_q == 2'd0) begin
          acc_d = cap_q;
        end else begin
          unique case (mode_q)
            MODE_AND: acc_d = acc_q & cap_q;
            MODE_XOR: acc_d = acc_q ^ cap_q;
            MODE_SINGLE, MODE_OR: acc_d = acc_q | cap_q;
          endcase
        end
        cap_d = '0;
        if (idx_q == last_idx(mode_q)) begin
          state_d = S_COUNT;
        end else begin
          idx_d = idx_q + 2'd1;
          if (circ_ok(next_c)) begin
            state_d = S_LOAD;
            mx_d    = next_c.x;
            my_d    = next_c.y;
            mr_d    = next_c.r;
          end else begin
            state_d = S_COMBINE;
          end
        end
      end
      S_COUNT: begin
        if (pc_done) begin
          count_d = pc_count;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign map_x     = mx_q;
  assign map_y     = my_q;
  assign map_r     = mr_q;
  assign map_reset = (state_q != S_WAIT);
  assign busy      = (state_q == S_LOAD) || (state_q == S_WAIT) ||
                     (state_q == S_COMBINE) || (state_q == S_COUNT);
  assign valid     = valid_q;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_SINGLE;
      central_q <= '0;
      radius_q  <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      cap_q     <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      mr_q      <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      cap_q     <= cap_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      mr_q      <= mr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_map_set_counter.sv
// Directed bench for map_set_counter driven by the reference map_gen.
// Expected counts, pulse counts and latencies are hand-computed.
module tb_map_set_counter;
  import map_set_counter_pkg::*;

`ifdef MAP_SET_SERIAL_COUNT_EN
  localparam int SER = 63;
`else
  localparam int SER = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [23:0] central = '0;
  logic [11:0] radius = '0;
  logic        busy, valid;
  logic [6:0]  count;

  map_set_counter_if lnk();

  map_set_counter dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .central   (central),
    .radius    (radius),
    .map_x     (lnk.map_x),
    .map_y     (lnk.map_y),
    .map_r     (lnk.map_r),
    .map_reset (lnk.map_reset),
    .map       (lnk.map),
    .map_done  (lnk.map_done),
    .busy      (busy),
    .valid     (valid),
    .count     (count)
  );

  map_gen u_gen (
    .clk   (clk),
    .rst_n (reset),
    .g     (lnk.slave)
  );

  always #5 clk = ~clk;

  int   mr_falls = 0;
  logic mr_prev = 1'b1;

  always @(negedge clk) begin
    if (mr_prev && !lnk.map_reset) mr_falls <= mr_falls + 1;
    mr_prev <= lnk.map_reset;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge where valid is seen
  task automatic run_job(
    input  string       tag,
    input  logic [1:0]  m,
    input  logic [23:0] c,
    input  logic [11:0] r,
    output int          cnt,
    output int          lat,
    output int          pulses
  );
    int base;
    base    = mr_falls;
    mode    = m;
    central = c;
    radius  = r;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid_seen"}, int'(valid), 1);
    cnt    = int'(count);
    pulses = mr_falls - base;
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [23:0] c;
    logic [11:0] r;
    int          cnt;
    int          pulses;
    int          lat;
  } vec_t;

  vec_t vt[11];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt, lat, pulses, vseen;

    vt[0]  = '{2'd0, 24'h440000, 12'h000, 1,  1, 8};
    vt[1]  = '{2'd0, 24'h440000, 12'h100, 5,  1, 8};
    vt[2]  = '{2'd1, 24'h444400, 12'h110, 5,  2, 14};
    vt[3]  = '{2'd2, 24'h444400, 12'h110, 0,  2, 14};
    vt[4]  = '{2'd3, 24'h444444, 12'hccc, 64, 3, 20};
    vt[5]  = '{2'd1, 24'h440400, 12'h100, 0,  1, 9};
    vt[6]  = '{2'd3, 24'h118891, 12'h000, 2,  2, 15};
    vt[7]  = '{2'd2, 24'h112100, 12'h100, 2,  2, 14};
    vt[8]  = '{2'd0, 24'h000000, 12'h000, 0,  0, 3};
    vt[9]  = '{2'd0, 24'h880000, 12'h200, 6,  1, 8};
    vt[10] = '{2'd1, 24'h118800, 12'h000, 0,  2, 14};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_map_reset", int'(lnk.map_reset), 1);
    chk("rst_map_xyr", int'({lnk.map_x, lnk.map_y, lnk.map_r}), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_job($sformatf("v%0d", i), vt[i].m, vt[i].c, vt[i].r,
              cnt, lat, pulses);
      chk($sformatf("v%0d_count", i), cnt, vt[i].cnt);
      chk($sformatf("v%0d_pulses", i), pulses, vt[i].pulses);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat + SER);
      @(negedge clk);
      chk($sformatf("v%0d_valid_1cyc", i), int'(valid), 0);
      chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      chk($sformatf("v%0d_count_hold", i), int'(count), vt[i].cnt);
    end

    // new job started in the same cycle that shows valid
    run_job("chain_a", 2'd2, 24'h444400, 12'h110, cnt, lat, pulses);
    chk("chain_a_count", cnt, 0);
    run_job("chain_b", 2'd0, 24'h440000, 12'h100, cnt, lat, pulses);
    chk("chain_b_count", cnt, 5);
    chk("chain_b_latency", lat, 8 + SER);
    @(negedge clk);

    // start during WAIT must not relatch
    begin
      int base;
      base    = mr_falls;
      mode    = 2'd0;
      central = 24'h440000;
      radius  = 12'h100;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("wait_map_reset", int'(lnk.map_reset), 0);
      chk("wait_busy", int'(busy), 1);
      mode    = 2'd3;
      central = 24'h333333;
      radius  = 12'hccc;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      while (!valid && lat < 300) begin
        @(negedge clk);
        lat++;
      end
      chk("wait_valid_seen", int'(valid), 1);
      chk("wait_count", int'(count), 5);
      chk("wait_map_x", int'(lnk.map_x), 4);
      chk("wait_pulses", mr_falls - base, 1);
    end
    @(negedge clk);

    // reset asserted for one edge while in COUNT
    mode    = 2'd0;
    central = 24'h440000;
    radius  = 12'h100;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("cnt_busy", int'(busy), 1);
    chk("cnt_map_reset", int'(lnk.map_reset), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_count", int'(count), 0);
    chk("abort_map_x", int'(lnk.map_x), 0);
    vseen = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid) vseen++;
    end
    chk("abort_no_valid", vseen, 0);
    run_job("post", 2'd0, 24'h440000, 12'h000, cnt, lat, pulses);
    chk("post_count", cnt, 1);
    chk("post_latency", lat, 8 + SER);
    chk("post_pulses", pulses, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
